// File: rtl/parser_mw_if.sv
// Handshake bundle between the instruction source, the parser and the command consumer.
// The parser drives the decoded record; the master side supplies words and out_ready.
interface parser_mw_if #(
    parameter int INST_W = 32,
    parameter int DATA_W = 16,
    parameter int SIDX_W = 19
);
    logic [INST_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_itype;
    logic [4:0]        out_prop;
    logic [4:0]        out_prop2;
    logic [5:0]        out_lidx;
    logic [SIDX_W-1:0] out_sidx;
    logic [4:0]        out_stype;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] out_data2;
    logic [2:0]        out_seq;
    logic              out_last;
    logic              err;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_valid, out_itype, out_prop, out_prop2, out_lidx,
               out_sidx, out_stype, out_data, out_data2, out_seq, out_last, err
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_valid, out_itype, out_prop, out_prop2, out_lidx,
               out_sidx, out_stype, out_data, out_data2, out_seq, out_last, err
    );
endinterface

// File: rtl/parser_mw.sv
// Instruction parser with valid/ready on both sides and a multi-word shape-set payload.
// One output register: a record appears one cycle after its word is accepted.
module parser_mw #(
    parameter int INST_W         = 32,
    parameter int DATA_W         = 16,
    parameter int MAX_DATA_WORDS = 4,
    parameter int SIDX_W         = 19
) (
    input  logic         clk,
    input  logic         rst,
    parser_mw_if.slave   bus
);
    localparam logic [3:0] MAX_N = 4'(MAX_DATA_WORDS);

    typedef enum logic {IDLE, DATA} state_t;

    state_t            state;
    logic [3:0]        remaining;
    logic [3:0]        n_words;
    logic [SIDX_W-1:0] grp_sidx;

    logic              xfer;
    logic [31:0]       w;
    logic [18:0]       sidx_raw;
    logic [3:0]        n_req;
    logic [3:0]        n_clamp;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign xfer         = bus.in_valid && bus.in_ready;
    assign w            = bus.in_data[31:0];
    assign sidx_raw     = {w[31:16], w[5:3]};
    assign n_req        = {1'b0, w[8:6]} + 4'd1;
    assign n_clamp      = (n_req > MAX_N) ? MAX_N : n_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            remaining     <= '0;
            n_words       <= '0;
            grp_sidx      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_itype <= '0;
            bus.out_prop  <= '0;
            bus.out_prop2 <= '0;
            bus.out_lidx  <= '0;
            bus.out_sidx  <= '0;
            bus.out_stype <= '0;
            bus.out_data  <= '0;
            bus.out_data2 <= '0;
            bus.out_seq   <= '0;
            bus.out_last  <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready)
                bus.out_valid <= 1'b0;
            if (xfer) begin
                // Every accepted word rewrites the full record so no field goes stale.
                bus.out_valid <= 1'b1;
                bus.out_itype <= '0;
                bus.out_prop  <= '0;
                bus.out_prop2 <= '0;
                bus.out_lidx  <= '0;
                bus.out_sidx  <= '0;
                bus.out_stype <= '0;
                bus.out_data  <= '0;
                bus.out_data2 <= '0;
                bus.out_seq   <= '0;
                bus.out_last  <= 1'b1;
                if (state == DATA) begin
                    bus.out_itype <= 3'd7;
                    bus.out_sidx  <= grp_sidx;
                    bus.out_data  <= DATA_W'(w[31:16]);
                    bus.out_data2 <= DATA_W'(w[15:0]);
                    bus.out_seq   <= 3'(n_words - remaining);
                    bus.out_last  <= (remaining == 4'd1);
                    remaining     <= remaining - 4'd1;
                    if (remaining == 4'd1)
                        state <= IDLE;
                end else begin
                    case (w[2:0])
                        3'd0: bus.out_itype <= (w[10:9] == 2'd0) ? 3'd1 : 3'd2;
                        3'd1: begin
                            bus.out_itype <= 3'd3;
                            bus.out_prop  <= w[15:11];
                            bus.out_data  <= DATA_W'(w[31:16]);
                        end
                        3'd2: begin
                            bus.out_itype <= 3'd4;
                            bus.out_lidx  <= w[8:3];
                            bus.out_prop  <= w[15:11];
                            bus.out_data  <= DATA_W'(w[31:16]);
                        end
                        3'd3: begin
                            bus.out_itype <= 3'd5;
                            bus.out_sidx  <= SIDX_W'(sidx_raw);
                            bus.out_stype <= w[15:11];
                        end
                        3'd4: begin
                            // Oversized payload requests are flagged but still clamped.
                            bus.out_itype <= 3'd6;
                            bus.out_sidx  <= SIDX_W'(sidx_raw);
                            bus.out_prop  <= w[15:11];
                            bus.out_prop2 <= w[10:6];
                            bus.out_last  <= 1'b0;
                            grp_sidx      <= SIDX_W'(sidx_raw);
                            n_words       <= n_clamp;
                            remaining     <= n_clamp;
                            state         <= DATA;
                            if (n_req > MAX_N)
                                bus.err <= 1'b1;
                        end
                        default: bus.err <= 1'b1;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_parser_mw.sv
// Directed bench for parser_mw: one instance at default payload depth, one limited to two words.
module tb_parser_mw;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    parser_mw_if #(.INST_W(32), .DATA_W(16), .SIDX_W(19)) bus_a ();
    parser_mw_if #(.INST_W(32), .DATA_W(16), .SIDX_W(19)) bus_b ();

    parser_mw #(.INST_W(32), .DATA_W(16), .MAX_DATA_WORDS(4), .SIDX_W(19)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    parser_mw #(.INST_W(32), .DATA_W(16), .MAX_DATA_WORDS(2), .SIDX_W(19)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic send_a(input logic [31:0] word);
        bus_a.in_data  = word;
        bus_a.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] word);
        bus_b.in_data  = word;
        bus_b.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_b.in_valid = 1'b0;
    endtask

    logic [31:0] grp_words [4];

    initial begin
        grp_words[0] = 32'h1111_2222;
        grp_words[1] = 32'h3333_4444;
        grp_words[2] = 32'h5555_6666;
        grp_words[3] = 32'h7777_8888;

        rst = 1'b0;
        bus_a.in_data = '0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
        bus_b.in_data = '0; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
        #3;
        chk("reset out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("reset err", 64'(bus_a.err), 64'd0);
        chk("reset itype", 64'(bus_a.out_itype), 64'd0);
        chk("reset in_ready", 64'(bus_a.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        // Single-word decodes.
        send_a(32'h1234_2801);
        chk("cam valid", 64'(bus_a.out_valid), 64'd1);
        chk("cam itype", 64'(bus_a.out_itype), 64'd3);
        chk("cam prop", 64'(bus_a.out_prop), 64'd5);
        chk("cam data", 64'(bus_a.out_data), 64'h1234);
        chk("cam last", 64'(bus_a.out_last), 64'd1);
        send_a(32'h00FF_1812);
        chk("light itype", 64'(bus_a.out_itype), 64'd4);
        chk("light lidx", 64'(bus_a.out_lidx), 64'd2);
        chk("light prop", 64'(bus_a.out_prop), 64'd3);
        chk("light data", 64'(bus_a.out_data), 64'h00FF);
        send_a(32'h0001_2023);
        chk("sinit itype", 64'(bus_a.out_itype), 64'd5);
        chk("sinit sidx", 64'(bus_a.out_sidx), 64'hC);
        chk("sinit stype", 64'(bus_a.out_stype), 64'd4);
        chk("sinit data", 64'(bus_a.out_data), 64'd0);
        send_a(32'h0000_0200);
        chk("frame itype", 64'(bus_a.out_itype), 64'd2);

        // Four-word shape-set group.
        send_a(32'hABCD_00C4);
        chk("sset itype", 64'(bus_a.out_itype), 64'd6);
        chk("sset sidx", 64'(bus_a.out_sidx), 64'h55E68);
        chk("sset prop2", 64'(bus_a.out_prop2), 64'd3);
        chk("sset last", 64'(bus_a.out_last), 64'd0);
        for (int i = 0; i < 4; i++) begin
            send_a(grp_words[i]);
            chk($sformatf("sdata%0d itype", i), 64'(bus_a.out_itype), 64'd7);
            chk($sformatf("sdata%0d seq", i), 64'(bus_a.out_seq), 64'(i));
            chk($sformatf("sdata%0d data", i), 64'(bus_a.out_data), 64'(grp_words[i][31:16]));
            chk($sformatf("sdata%0d data2", i), 64'(bus_a.out_data2), 64'(grp_words[i][15:0]));
            chk($sformatf("sdata%0d sidx", i), 64'(bus_a.out_sidx), 64'h55E68);
            chk($sformatf("sdata%0d last", i), 64'(bus_a.out_last), (i == 3) ? 64'd1 : 64'd0);
        end
        send_a(32'h0000_0000);
        chk("render itype", 64'(bus_a.out_itype), 64'd1);
        chk("render data", 64'(bus_a.out_data), 64'd0);
        chk("render sidx", 64'(bus_a.out_sidx), 64'd0);
        chk("render seq", 64'(bus_a.out_seq), 64'd0);

        // Backpressure inside a three-word group.
        send_a(32'h0000_0084);
        chk("bp sset itype", 64'(bus_a.out_itype), 64'd6);
        send_a(32'hAAAA_0001);
        chk("bp seq0", 64'(bus_a.out_seq), 64'd0);
        bus_a.out_ready = 1'b0;
        bus_a.in_data   = 32'hBBBB_0002;
        bus_a.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d in_ready", i), 64'(bus_a.in_ready), 64'd0);
            chk($sformatf("bp%0d valid", i), 64'(bus_a.out_valid), 64'd1);
            chk($sformatf("bp%0d data", i), 64'(bus_a.out_data), 64'hAAAA);
            chk($sformatf("bp%0d seq", i), 64'(bus_a.out_seq), 64'd0);
        end
        bus_a.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
        chk("bp seq1", 64'(bus_a.out_seq), 64'd1);
        chk("bp seq1 data", 64'(bus_a.out_data), 64'hBBBB);
        chk("bp seq1 last", 64'(bus_a.out_last), 64'd0);
        send_a(32'hCCCC_0003);
        chk("bp seq2", 64'(bus_a.out_seq), 64'd2);
        chk("bp seq2 data2", 64'(bus_a.out_data2), 64'h0003);
        chk("bp seq2 last", 64'(bus_a.out_last), 64'd1);
        send_a(32'h0000_0001);
        chk("bp after itype", 64'(bus_a.out_itype), 64'd3);

        // Unsupported opcode and sticky error.
        send_a(32'h0000_0006);
        chk("op6 itype", 64'(bus_a.out_itype), 64'd0);
        chk("op6 err", 64'(bus_a.err), 64'd1);
        chk("op6 last", 64'(bus_a.out_last), 64'd1);
        send_a(32'h0000_0001);
        chk("sticky itype", 64'(bus_a.out_itype), 64'd3);
        chk("sticky err", 64'(bus_a.err), 64'd1);

        // Asynchronous reset with two payload words still outstanding.
        send_a(32'h0000_0084);
        send_a(32'hDDDD_0001);
        chk("pre-rst seq", 64'(bus_a.out_seq), 64'd0);
        rst = 1'b0;
        #1;
        chk("async rst valid", 64'(bus_a.out_valid), 64'd0);
        chk("async rst err", 64'(bus_a.err), 64'd0);
        chk("async rst itype", 64'(bus_a.out_itype), 64'd0);
        chk("async rst data", 64'(bus_a.out_data), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        send_a(32'h0000_0001);
        chk("post-rst itype", 64'(bus_a.out_itype), 64'd3);
        chk("post-rst valid", 64'(bus_a.out_valid), 64'd1);
        chk("post-rst last", 64'(bus_a.out_last), 64'd1);

        // Payload overflow on the two-word instance.
        chk("ovf err before", 64'(bus_b.err), 64'd0);
        send_b(32'h0000_0144);
        chk("ovf sset itype", 64'(bus_b.out_itype), 64'd6);
        chk("ovf err", 64'(bus_b.err), 64'd1);
        chk("ovf prop2", 64'(bus_b.out_prop2), 64'd5);
        send_b(32'h1111_2222);
        chk("ovf seq0 itype", 64'(bus_b.out_itype), 64'd7);
        chk("ovf seq0 last", 64'(bus_b.out_last), 64'd0);
        send_b(32'h3333_4444);
        chk("ovf seq1", 64'(bus_b.out_seq), 64'd1);
        chk("ovf seq1 last", 64'(bus_b.out_last), 64'd1);
        send_b(32'h0000_0001);
        chk("ovf idle itype", 64'(bus_b.out_itype), 64'd3);
        chk("ovf err sticky", 64'(bus_b.err), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/parser_mw.md
Name: parser_mw

Overview:
- Parametrised successor to the single-word instruction parser; sits between the instruction fetch/FIFO and the renderer's command dispatch.
- Decodes 32-bit instruction words into a decoded-instruction record.
- Adds valid/ready backpressure on both sides.
- Adds a configurable multi-word payload: a shape-set instruction is followed by 1..MAX_DATA_WORDS data words, not exactly one.
- Adds a sticky error flag for malformed streams.

Parameters:
- INST_W, 32, instruction word width; must be >= 32, bits above 31 ignored.
- DATA_W, 16, width of data/data2 output fields; payload halves are zero-extended or truncated to this width.
- MAX_DATA_WORDS, 4, maximum payload words after a shape-set; range 1..8.
- SIDX_W, 19, shape index width; sidx = {instr[31:16], instr[5:3]} zero-extended or truncated.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_data  in  INST_W  instruction word
- in_valid  in  1  in_data valid
- in_ready  out  1  parser accepts in_data this cycle
- out_valid  out  1  decoded record valid
- out_ready  in  1  consumer accepts the record
- out_itype  out  3  0 unsupported, 1 render, 2 frame, 3 camera_set, 4 light_set, 5 shape_init, 6 shape_set, 7 shape_data
- out_prop  out  5  property field
- out_prop2  out  5  secondary property field
- out_lidx  out  6  light index
- out_sidx  out  SIDX_W  shape index
- out_stype  out  5  shape type
- out_data  out  DATA_W  primary data
- out_data2  out  DATA_W  secondary data
- out_seq  out  3  payload word index for shape_data; 0 otherwise
- out_last  out  1  last word of an instruction group
- err  out  1  sticky malformed-stream flag

Behaviour:
- Reset (rst low, async): state=IDLE, out_valid=0, all out_* fields=0, err=0, remaining count=0. Takes effect immediately, even mid-group or mid-handshake.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (single output register, no skid buffer).
  - While out_valid=1 and out_ready=0, all out_* fields are held stable.
- Latency: exactly 1 cycle from input transfer to out_valid. Back-to-back throughput is 1 word per cycle when out_ready=1.
- Opcode = in_data[2:0] in IDLE:
  - 0 F-type: in[10:9]==0 -> render, else frame; out_last=1.
  - 1 C-type: camera_set; prop=in[15:11], data=in[31:16]; out_last=1.
  - 2 L-type: light_set; lidx=in[8:3], prop=in[15:11], data=in[31:16]; out_last=1.
  - 3 SI-type: shape_init; sidx, stype=in[15:11]; out_last=1.
  - 4 SE-type: shape_set; sidx, prop=in[15:11], prop2=in[10:6]; out_last=0.
    - N = in[8:6]+1, saturated at MAX_DATA_WORDS.
    - If in[8:6]+1 > MAX_DATA_WORDS: err <= 1, and N is still clamped.
    - Next state DATA with remaining=N.
  - 5..7: unsupported; err <= 1; out_last=1.
- Fields not listed for an itype are driven 0. Decoded fields never retain stale values.
- DATA state:
  - Every accepted word is shape_data, regardless of its low bits.
  - data=in[31:16], data2=in[15:0], seq=N-remaining, sidx repeats the group's sidx.
  - On acceptance, remaining decrements. When it reaches 0, out_last=1 and the next state is IDLE.
- State advances only on input transfer. in_valid low or backpressure stalls without losing count.
- err clears only on reset.

Test Plan:
- Reset mid-stream: assert rst low during DATA with remaining=2 -> out_valid=0 and err=0 immediately. Next word 0x0000_0001 decodes as camera_set.
- Camera word 0x1234_2801 -> one cycle later: itype=3, prop=5, data=0x1234, out_last=1.
- Shape-set 0xABCD_00C4 (in[8:6]=3, N=4), then words 0x1111_2222..0x7777_8888 -> five records: shape_set with sidx={0xABCD,0}, then shape_data with seq 0..3 and data/data2 per word; out_last=1 only on seq 3. Next word 0x0000_0000 decodes as render.
- Backpressure: hold out_ready=0 for 3 cycles during a shape_data group -> in_ready=0, outputs stable, no words lost or duplicated; seq continues correctly.
- Overflow with MAX_DATA_WORDS=2: SE word with in[8:6]=5 -> err=1, exactly 2 shape_data records follow, then IDLE decoding resumes.
- Opcode 6 word -> itype=0, err=1. err remains 1 after subsequent valid traffic until rst is asserted.
